// File: rtl/store_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_ctrl
// Brief    : In-order store buffer with commit/flush tracking, store-to-load
//            forwarding and a single-port bus arbiter (drain vs. load read).
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_ctrl #(
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 3,
    parameter int ROB_ID_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROB_ID_WIDTH-1:0] exlsu_stbuf_rob_id,
    input  logic [ADDR_WIDTH-1:0]   exlsu_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]   exlsu_stbuf_write_size,
    input  logic [DATA_WIDTH-1:0]   exlsu_stbuf_write_data,
    input  logic                    exlsu_stbuf_push,
    output logic                    stbuf_exlsu_full,
    input  logic [ADDR_WIDTH-1:0]   exlsu_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]   exlsu_stbuf_read_size,
    input  logic                    exlsu_stbuf_read_req,
    output logic [DATA_WIDTH-1:0]   stbuf_exlsu_bus_data_feedback,
    output logic                    stbuf_exlsu_bus_ready,
    input  logic                    commit_enable,
    input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
    input  logic                    commit_flush,
    output logic                    bus_req,
    output logic                    bus_write,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [SIZE_WIDTH-1:0]   bus_size,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DEPTH-1:0]        ent_valid, ent_committed;
    logic [DEPTH-1:0]        valid_nx, committed_nx;
    logic [ROB_ID_WIDTH-1:0] ent_rob  [DEPTH];
    logic [ADDR_WIDTH-1:0]   ent_addr [DEPTH];
    logic [SIZE_WIDTH-1:0]   ent_size [DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data [DEPTH];

    logic [PTR_W-1:0] head, tail, cptr, cptr_nx, scan_idx, fwd_idx;
    logic [CNT_W-1:0] count, ccount, ccount_nx;
    logic             abort;
    logic             full, do_push, do_pop, do_commit, head_drain;
    logic             fwd_found, fwd_hit, need_read, start_wr, start_rd;
    logic [ADDR_WIDTH:0] ld_lo, ld_hi, st_lo, st_hi;

    assign full             = (count == CNT_W'(DEPTH));
    assign stbuf_exlsu_full = full;
    // A flushed push belongs to a squashed instruction, so it is dropped.
    assign do_push    = exlsu_stbuf_push && !full && !commit_flush;
    assign do_pop     = (state == WR_WAIT) && bus_ack;
    assign do_commit  = commit_enable && ent_valid[cptr] && !ent_committed[cptr]
                        && (ent_rob[cptr] == commit_rob_id);
    assign cptr_nx    = do_commit ? cptr + 1'b1 : cptr;
    assign ccount_nx  = ccount + CNT_W'(do_commit) - CNT_W'(do_pop);
    assign head_drain = ent_valid[head] && ent_committed[head];

    // Youngest valid entry whose byte range overlaps the load; scan oldest to youngest.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = '0;
        scan_idx  = '0;
        ld_lo     = {1'b0, exlsu_stbuf_read_addr};
        ld_hi     = ld_lo + {{(ADDR_WIDTH+1-SIZE_WIDTH){1'b0}}, exlsu_stbuf_read_size};
        st_lo     = '0;
        st_hi     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            st_lo    = {1'b0, ent_addr[scan_idx]};
            st_hi    = st_lo + {{(ADDR_WIDTH+1-SIZE_WIDTH){1'b0}}, ent_size[scan_idx]};
            if (ent_valid[scan_idx] && (st_lo < ld_hi) && (ld_lo < st_hi)) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
    end

    assign fwd_hit   = fwd_found && (ent_addr[fwd_idx] == exlsu_stbuf_read_addr)
                       && (ent_size[fwd_idx] >= exlsu_stbuf_read_size);
    assign need_read = exlsu_stbuf_read_req && !fwd_found;

    // Next-state logic; a full buffer forces a drain ahead of any load read.
    always_comb begin
        state_nx = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        case (state)
            IDLE: begin
                if (head_drain && (full || !need_read)) begin
                    state_nx = WR_WAIT;
                    start_wr = 1'b1;
                end else if (need_read && !commit_flush) begin
                    state_nx = RD_WAIT;
                    start_rd = 1'b1;
                end
            end
            WR_WAIT: if (bus_ack) state_nx = IDLE;
            RD_WAIT: if (bus_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Load response: bus read data on an un-aborted ack, otherwise a forwarding hit.
    always_comb begin
        stbuf_exlsu_bus_ready         = 1'b0;
        stbuf_exlsu_bus_data_feedback = '0;
        if (state == RD_WAIT) begin
            if (bus_ack && !abort && exlsu_stbuf_read_req && !commit_flush) begin
                stbuf_exlsu_bus_ready         = 1'b1;
                stbuf_exlsu_bus_data_feedback = bus_rdata;
            end
        end else if (exlsu_stbuf_read_req && fwd_hit) begin
            stbuf_exlsu_bus_ready         = 1'b1;
            stbuf_exlsu_bus_data_feedback = ent_data[fwd_idx];
        end
    end

    // Entry flag update order: commit, pop, flush, then push.
    always_comb begin
        valid_nx     = ent_valid;
        committed_nx = ent_committed;
        if (do_commit) committed_nx[cptr] = 1'b1;
        if (do_pop) begin
            valid_nx[head]     = 1'b0;
            committed_nx[head] = 1'b0;
        end
        if (commit_flush) valid_nx = valid_nx & committed_nx;
        if (do_push) begin
            valid_nx[tail]     = 1'b1;
            committed_nx[tail] = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Pointers, occupancy and entry flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            cptr          <= '0;
            count         <= '0;
            ccount        <= '0;
            ent_valid     <= '0;
            ent_committed <= '0;
        end else begin
            ent_valid     <= valid_nx;
            ent_committed <= committed_nx;
            cptr          <= cptr_nx;
            ccount        <= ccount_nx;
            if (do_pop) head <= head + 1'b1;
            if (commit_flush) begin
                tail  <= cptr_nx;
                count <= ccount_nx;
            end else begin
                if (do_push) tail <= tail + 1'b1;
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_rob[tail]  <= exlsu_stbuf_rob_id;
            ent_addr[tail] <= exlsu_stbuf_write_addr;
            ent_size[tail] <= exlsu_stbuf_write_size;
            ent_data[tail] <= exlsu_stbuf_write_data;
        end
    end

    // Registered bus request, captured only when a transaction starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_size  <= '0;
            bus_wdata <= '0;
        end else if (start_wr) begin
            bus_req   <= 1'b1;
            bus_write <= 1'b1;
            bus_addr  <= ent_addr[head];
            bus_size  <= ent_size[head];
            bus_wdata <= ent_data[head];
        end else if (start_rd) begin
            bus_req   <= 1'b1;
            bus_write <= 1'b0;
            bus_addr  <= exlsu_stbuf_read_addr;
            bus_size  <= exlsu_stbuf_read_size;
            bus_wdata <= '0;
        end else if (bus_ack) begin
            bus_req   <= 1'b0;
        end
    end

    // Abort marks an outstanding read whose load was flushed or withdrawn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort <= 1'b0;
        end else if (start_rd) begin
            abort <= 1'b0;
        end else if (state == RD_WAIT) begin
            if (bus_ack)                                    abort <= 1'b0;
            else if (commit_flush || !exlsu_stbuf_read_req) abort <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer_ctrl
// Brief    : Directed scenarios plus randomized traffic for store_buffer_ctrl,
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  st_rob = '0;
    logic [31:0] st_addr = '0;
    logic [2:0]  st_size = '0;
    logic [31:0] st_data = '0;
    logic        push = 1'b0;
    logic        full;
    logic [31:0] rd_addr = '0;
    logic [2:0]  rd_size = '0;
    logic        rd_req = 1'b0;
    logic [31:0] feedback;
    logic        ready;
    logic        c_en = 1'b0;
    logic [6:0]  c_rob = '0;
    logic        flush = 1'b0;
    logic        bus_req, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [2:0]  bus_size;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    store_buffer_ctrl dut (
        .clk                           (clk),
        .rst                           (rst),
        .exlsu_stbuf_rob_id            (st_rob),
        .exlsu_stbuf_write_addr        (st_addr),
        .exlsu_stbuf_write_size        (st_size),
        .exlsu_stbuf_write_data        (st_data),
        .exlsu_stbuf_push              (push),
        .stbuf_exlsu_full              (full),
        .exlsu_stbuf_read_addr         (rd_addr),
        .exlsu_stbuf_read_size         (rd_size),
        .exlsu_stbuf_read_req          (rd_req),
        .stbuf_exlsu_bus_data_feedback (feedback),
        .stbuf_exlsu_bus_ready         (ready),
        .commit_enable                 (c_en),
        .commit_rob_id                 (c_rob),
        .commit_flush                  (flush),
        .bus_req                       (bus_req),
        .bus_write                     (bus_write),
        .bus_addr                      (bus_addr),
        .bus_size                      (bus_size),
        .bus_wdata                     (bus_wdata),
        .bus_ack                       (bus_ack),
        .bus_rdata                     (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [6:0]  rob;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        comm;
    } ent_t;

    ent_t        q[$];
    int          mst = 0;          // 0: no bus transaction, 1: write, 2: read
    bit          alive = 0;        // outstanding read still wanted by its load
    logic        m_req = 0, m_wr = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [2:0]  m_size = 0;
    bit          ready_seen = 0;

    bit          found, need_read, headc, full0, exp_rdy;
    int          fidx;
    logic [31:0] exp_fb;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mst = 0; alive = 0; m_req = 0; m_wr = 0;
            m_addr = 0; m_wdata = 0; m_size = 0; ready_seen = 0;
        end else begin
            found = 0; fidx = 0;
            for (int i = 0; i < q.size(); i++) begin
                if (longint'(q[i].addr) < longint'(rd_addr) + longint'(rd_size) &&
                    longint'(rd_addr) < longint'(q[i].addr) + longint'(q[i].size)) begin
                    found = 1; fidx = i;
                end
            end
            exp_rdy = 0; exp_fb = 0;
            if (mst == 2) begin
                if (bus_ack && alive && rd_req && !flush) begin
                    exp_rdy = 1; exp_fb = bus_rdata;
                end
            end else if (rd_req && found && q[fidx].addr == rd_addr && q[fidx].size >= rd_size) begin
                exp_rdy = 1; exp_fb = q[fidx].data;
            end
            full0 = (q.size() == 16);
            chk("full", full, full0);
            chk("ready", ready, exp_rdy);
            chk("feedback", feedback, exp_fb);
            chk("bus_req", bus_req, m_req);
            if (m_req) begin
                chk("bus_write", bus_write, m_wr);
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_size", bus_size, m_size);
                chk("bus_wdata", bus_wdata, m_wdata);
            end
            ready_seen = exp_rdy;

            // bus transaction progress
            need_read = rd_req && !found;
            headc = (q.size() > 0) && q[0].comm;
            if (mst == 0) begin
                if (headc && (full0 || !need_read)) begin
                    mst = 1; m_req = 1; m_wr = 1;
                    m_addr = q[0].addr; m_size = q[0].size; m_wdata = q[0].data;
                end else if (need_read && !flush) begin
                    mst = 2; m_req = 1; m_wr = 0; alive = 1;
                    m_addr = rd_addr; m_size = rd_size; m_wdata = 0;
                end
            end else if (mst == 2 && !bus_ack && (flush || !rd_req)) begin
                alive = 0;
            end

            // buffer contents: commit, pop, flush, push
            if (c_en) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (!q[j].comm) begin
                        if (q[j].rob == c_rob) q[j].comm = 1;
                        break;
                    end
                end
            end
            if (bus_ack && mst == 1 && m_req) begin
                void'(q.pop_front());
                mst = 0; m_req = 0;
            end else if (bus_ack && mst == 2 && m_req) begin
                mst = 0; m_req = 0;
            end
            if (flush) begin
                while (q.size() > 0) begin
                    if (q[q.size()-1].comm) break;
                    void'(q.pop_back());
                end
            end else if (push && !full0) begin
                q.push_back('{rob: st_rob, addr: st_addr, size: st_size, data: st_data, comm: 1'b0});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!bus_req && n < 40) begin
            tick();
            n++;
        end
        #1;
        chk(nm, bus_req, 1'b1);
    endtask

    task automatic ack_once();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic do_push(input logic [6:0] r, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        tick();
        push = 1'b1; st_rob = r; st_addr = a; st_size = s; st_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_commit(input logic [6:0] r);
        c_en = 1'b1; c_rob = r;
        tick();
        c_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_full"}, full, 0);
        chk({nm, "_ready"}, ready, 0);
        chk({nm, "_fb"}, feedback, 0);
        chk({nm, "_req"}, bus_req, 0);
        chk({nm, "_wr"}, bus_write, 0);
        chk({nm, "_addr"}, bus_addr, 0);
        chk({nm, "_size"}, bus_size, 0);
        chk({nm, "_wdata"}, bus_wdata, 0);
    endtask

    function automatic logic [6:0] oldest_uncommitted(input logic [6:0] dflt);
        for (int j = 0; j < q.size(); j++)
            if (!q[j].comm) return q[j].rob;
        return dflt;
    endfunction

    initial begin
        logic [6:0]  next_rob;
        bit          ld_active;
        bit          flush_last;
        logic [2:0]  sz;
        int          r;

        repeat (3) tick();
        #1 chk_all_zero("reset");
        tick();
        rst = 1'b1;

        // Test 1: committed word store drains to the bus.
        do_push(7'd5, 32'h100, 3'd4, 32'hDEADBEEF);
        do_commit(7'd5);
        wait_req("t1_req");
        chk("t1_write", bus_write, 1);
        chk("t1_addr", bus_addr, 32'h100);
        chk("t1_wdata", bus_wdata, 32'hDEADBEEF);
        ack_once();
        repeat (3) tick();
        chk("t1_idle", bus_req, 0);

        // Test 3: full forward of a halfword load from a word store.
        do_push(7'd6, 32'h300, 3'd4, 32'h12345678);
        rd_req = 1'b1; rd_addr = 32'h300; rd_size = 3'd2;
        #1;
        chk("t3_ready", ready, 1);
        chk("t3_fb", feedback, 32'h12345678);
        chk("t3_noreq", bus_req, 0);
        tick();
        rd_req = 1'b0;
        do_commit(7'd6);
        wait_req("t3_drain");
        ack_once();

        // Test 2: partial overlap stalls, then a bus read after the drain.
        do_push(7'd7, 32'h200, 3'd1, 32'h7F);
        rd_req = 1'b1; rd_addr = 32'h200; rd_size = 3'd4;
        #1 chk("t2_stall", ready, 0);
        tick();
        #1 chk("t2_noreq", bus_req, 0);
        do_commit(7'd7);
        wait_req("t2_wr");
        chk("t2_wr_addr", bus_addr, 32'h200);
        chk("t2_wr_write", bus_write, 1);
        ack_once();
        wait_req("t2_rd");
        chk("t2_rd_write", bus_write, 0);
        chk("t2_rd_addr", bus_addr, 32'h200);
        chk("t2_rd_size", bus_size, 3'd4);
        bus_rdata = 32'hCAFEF00D; bus_ack = 1'b1;
        #1;
        chk("t2_ready", ready, 1);
        chk("t2_fb", feedback, 32'hCAFEF00D);
        tick();
        bus_ack = 1'b0; rd_req = 1'b0;

        // Test 4: fill, drop 17th, drain wins over a load while full.
        for (int k = 0; k < 16; k++) begin
            tick();
            push = 1'b1; st_rob = 7'(10 + k); st_addr = 32'h400 + 32'(4 * k);
            st_size = 3'd4; st_data = 32'h1000 + 32'(k);
        end
        tick();
        push = 1'b0;
        #1 chk("t4_full", full, 1);
        push = 1'b1; st_rob = 7'd26; st_addr = 32'h480; st_data = 32'hBAD;
        tick();
        push = 1'b0;
        for (int k = 0; k < 16; k++) do_commit(7'(10 + k));
        rd_req = 1'b1; rd_addr = 32'h800; rd_size = 3'd4;
        wait_req("t4_first");
        chk("t4_first_write", bus_write, 1);
        chk("t4_first_addr", bus_addr, 32'h400);
        ack_once();
        #1 chk("t4_notfull", full, 0);
        wait_req("t4_rd");
        chk("t4_rd_write", bus_write, 0);
        chk("t4_rd_addr", bus_addr, 32'h800);
        bus_rdata = 32'h55AA55AA; bus_ack = 1'b1;
        #1 chk("t4_rd_ready", ready, 1);
        tick();
        bus_ack = 1'b0; rd_req = 1'b0;
        for (int k = 1; k < 16; k++) begin
            wait_req("t4_drain");
            chk("t4_order", bus_addr, 32'h400 + 32'(4 * k));
            ack_once();
        end
        repeat (4) tick();
        chk("t4_dropped", bus_req, 0);

        // Test 5: flush keeps only the committed store.
        do_push(7'd30, 32'h500, 3'd4, 32'hA0);
        do_push(7'd31, 32'h504, 3'd4, 32'hA1);
        do_push(7'd32, 32'h508, 3'd4, 32'hA2);
        do_commit(7'd30);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_req("t5_req");
        chk("t5_addr", bus_addr, 32'h500);
        ack_once();
        repeat (5) tick();
        chk("t5_only_one", bus_req, 0);

        // Test 6: flushed read returns no data; reset during a write.
        rd_req = 1'b1; rd_addr = 32'h600; rd_size = 3'd4;
        wait_req("t6_rd");
        chk("t6_rd_write", bus_write, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0; rd_req = 1'b0; bus_ack = 1'b1;
        #1 chk("t6_abort", ready, 0);
        tick();
        bus_ack = 1'b0;
        do_push(7'd40, 32'h700, 3'd4, 32'h77);
        do_commit(7'd40);
        wait_req("t6_wr");
        chk("t6_wr_write", bus_write, 1);
        #1 rst = 1'b0;
        #1 chk_all_zero("t6_rst");
        tick();
        tick();
        rst = 1'b1;

        // Randomized traffic.
        next_rob = 7'd50; ld_active = 0; flush_last = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            push = 1'b0; c_en = 1'b0; flush = 1'b0;
            bus_rdata = $urandom;
            bus_ack = bus_req && ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 2);
                case (r)
                    0:       sz = 3'd1;
                    1:       sz = 3'd2;
                    default: sz = 3'd4;
                endcase
                push = 1'b1; st_rob = next_rob; next_rob = next_rob + 7'd1;
                st_size = sz; st_data = $urandom;
                st_addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
                if (sz == 3'd2) st_addr = st_addr + 32'(2 * $urandom_range(0, 1));
                if (sz == 3'd1) st_addr = st_addr + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) begin
                c_en = 1'b1;
                c_rob = ($urandom_range(0, 3) != 0) ? oldest_uncommitted(7'($urandom))
                                                    : 7'($urandom);
            end
            if (ld_active && (ready_seen || flush_last)) begin
                ld_active = 0; rd_req = 1'b0;
            end else if (!ld_active && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 2);
                case (r)
                    0:       sz = 3'd1;
                    1:       sz = 3'd2;
                    default: sz = 3'd4;
                endcase
                ld_active = 1; rd_req = 1'b1; rd_size = sz;
                rd_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                if (sz == 3'd2) rd_addr = rd_addr + 32'(2 * $urandom_range(0, 1));
                if (sz == 3'd1) rd_addr = rd_addr + 32'($urandom_range(0, 3));
            end
            flush = ($urandom_range(0, 39) == 0);
            flush_last = flush;
        end
        tick();
        push = 1'b0; c_en = 1'b0; flush = 1'b0; rd_req = 1'b0; bus_ack = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
